// File: rtl/fifo_data.sv
// fifo_data: flop-based FIFO storage with a combinational read port.
// Pointers, wrap-around and full/empty tracking belong to the owning controller.
module fifo_data #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DEPTH_NBITS = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DEPTH_NBITS-1:0] rptr,
    input  logic [DEPTH_NBITS-1:0] wptr,
    input  logic                   wr,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout
);

    localparam int unsigned DEPTH = 2 ** DEPTH_NBITS;

    logic [WIDTH-1:0] mem [DEPTH];

    // Synchronous clear has priority over a write; otherwise store din at wptr
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr) begin
            mem[wptr] <= din;
        end
    end

    // Fall-through read: no bypass, a same-address write shows after the edge
    assign dout = mem[rptr];

endmodule

// File: tb/tb_fifo_data.sv
// tb_fifo_data: table-driven and scoreboard checks for fifo_data at
// WIDTH=16/DEPTH_NBITS=1 and WIDTH=8/DEPTH_NBITS=3.
module tb_fifo_data;

    logic        clk;
    logic        rst_n;
    logic        wr;
    logic [0:0]  wptr;
    logic [0:0]  rptr;
    logic [15:0] din;
    logic [15:0] dout;

    logic        rst_n8;
    logic        wr8;
    logic [2:0]  wptr8;
    logic [2:0]  rptr8;
    logic [7:0]  din8;
    logic [7:0]  dout8;

    int n_vec;
    int n_miss;

    logic [15:0] exp_q[$];
    logic [7:0]  model8 [8];

    typedef struct {
        logic        rst_n;
        logic        wr;
        logic [0:0]  wptr;
        logic [0:0]  rptr;
        logic [15:0] din;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [19];

    fifo_data #(.WIDTH(16), .DEPTH_NBITS(1)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rptr  (rptr),
        .wptr  (wptr),
        .wr    (wr),
        .din   (din),
        .dout  (dout)
    );

    fifo_data #(.WIDTH(8), .DEPTH_NBITS(3)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n8),
        .rptr  (rptr8),
        .wptr  (wptr8),
        .wr    (wr8),
        .din   (din8),
        .dout  (dout8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Pop the oldest expected value and compare it against the observed dout
    task automatic sb_check(input string name, input logic [15:0] act);
        logic [15:0] e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL %s: scoreboard empty, dout=%h", name, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                n_miss++;
                $display("FAIL %s: dout=%h expected=%h", name, act, e);
            end
        end
    endtask

    initial begin
        string nm;
        n_vec  = 0;
        n_miss = 0;

        //               rst_n wr    wptr  rptr  din       exp (dout before the edge)
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'hA5A5, 16'h0000};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h5A5A, 16'hA5A5};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h5A5A};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hA5A5};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h1111, 16'h5A5A};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h2222, 16'h1111};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h3333, 16'h2222};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h5A5A};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h2222};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'hDEAD, 16'h5A5A};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'hBEEF, 16'h2222};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h5A5A};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFF, 16'h5A5A};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[17] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0BEE, 16'h0000};
        tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0BEE};

        rst_n  = 1'b0;
        wr     = 1'b0;
        wptr   = 1'b0;
        rptr   = 1'b0;
        din    = 16'h0000;
        rst_n8 = 1'b0;
        wr8    = 1'b0;
        wptr8  = 3'd0;
        rptr8  = 3'd0;
        din8   = 8'h00;

        // Reset held across two edges on both instances
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        rst_n8 = 1'b1;

        // Table: drive a record, predict dout before the edge, sample at negedge
        for (int i = 0; i < 19; i++) begin
            @(posedge clk);
            #1;
            rst_n = tbl[i].rst_n;
            wr    = tbl[i].wr;
            wptr  = tbl[i].wptr;
            rptr  = tbl[i].rptr;
            din   = tbl[i].din;
            exp_q.push_back(tbl[i].exp);
            @(negedge clk);
            nm = $sformatf("vec%0d", i);
            sb_check(nm, dout);
        end

        // Read pointer changes inside one cycle reach dout without an edge
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr    = 1'b0;
        rptr  = 1'b0;
        exp_q.push_back(16'h0000);
        #1;
        sb_check("rptr_same_cycle_0", dout);
        rptr = 1'b1;
        exp_q.push_back(16'h0BEE);
        #1;
        sb_check("rptr_same_cycle_1", dout);

        // rst_n pulsed low between edges leaves dout untouched
        @(posedge clk);
        #1;
        rptr  = 1'b1;
        rst_n = 1'b0;
        exp_q.push_back(16'h0BEE);
        #2;
        sb_check("rst_no_async", dout);
        rst_n = 1'b1;
        exp_q.push_back(16'h0BEE);
        @(negedge clk);
        sb_check("rst_no_async_post", dout);

        // Depth sweep on the 8-entry instance
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            wr8       = 1'b1;
            wptr8     = 3'(i);
            din8      = 8'(8'h10 + i);
            model8[i] = 8'(8'h10 + i);
        end
        @(posedge clk);
        #1;
        wr8  = 1'b0;
        din8 = 8'h55;
        for (int i = 0; i < 8; i++) begin
            rptr8 = 3'(i);
            exp_q.push_back({8'h00, model8[i]});
            #1;
            nm = $sformatf("sweep_rd%0d", i);
            sb_check(nm, {8'h00, dout8});
        end

        // Wrap write back to address 0 replaces only that entry
        @(posedge clk);
        #1;
        wr8       = 1'b1;
        wptr8     = 3'd0;
        din8      = 8'hEE;
        model8[0] = 8'hEE;
        @(posedge clk);
        #1;
        wr8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rptr8 = 3'(i);
            exp_q.push_back({8'h00, model8[i]});
            #1;
            nm = $sformatf("wrap_rd%0d", i);
            sb_check(nm, {8'h00, dout8});
        end

        if (exp_q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fifo_data.md
FIFO_DATA -- requirements
Module: fifo_data

Interface
REQ-001 Parameter WIDTH, default 16; data width in bits; legal range 1 or more.
REQ-002 Parameter DEPTH_NBITS, default 1; address width; storage depth is 2**DEPTH_NBITS entries; legal range 1 to 10.
REQ-003 Port clk, input, 1 bit; single clock, all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit; reset is synchronous and active-low.
REQ-005 Port rptr, input, DEPTH_NBITS bits; read address, driven by the owning FIFO controller.
REQ-006 Port wptr, input, DEPTH_NBITS bits; write address.
REQ-007 Port wr, input, 1 bit; write enable, sampled at the clock edge.
REQ-008 Port din, input, WIDTH bits; write data.
REQ-009 Port dout, output, WIDTH bits; read data, combinational from the storage array.

Function
REQ-010 Storage shall be a flop array of 2**DEPTH_NBITS entries, each WIDTH bits wide; no RAM macro.
REQ-011 On a rising clk edge with rst_n=1 and wr=1, entry[wptr] shall take din; all other entries hold.
REQ-012 With wr=0, no entry shall change.
REQ-013 dout shall equal entry[rptr] combinationally: zero-cycle read latency, fall-through behaviour.
REQ-014 A change on rptr shall be reflected on dout in the same cycle with no clock edge.
REQ-015 Write and read at the same address in the same cycle: dout shows the old entry until the edge, and the new din after the edge; there is no write-to-read bypass.
REQ-016 Pointers are used as given; wrap-around, full/empty tracking and overflow protection belong to the controller; no flags are generated here.
REQ-017 Write data shall be captured with no data-dependent gating; X or Z on din is stored unchanged.
REQ-018 Pointer widths shall exactly match DEPTH_NBITS; no truncation or extension.

Reset
REQ-019 On a rising clk edge with rst_n=0, every entry shall clear to all zeros, so dout reads 0 for any rptr.
REQ-020 Reset has priority over wr; a write in a reset cycle shall be discarded.
REQ-021 Reset asserted in the middle of operation shall clear the contents at the next edge; the first write after deassertion shall behave per REQ-011.
REQ-022 rst_n shall have no asynchronous effect; between edges, dout is unaffected by rst_n.

Verification (WIDTH=16, DEPTH_NBITS=1 unless noted)
REQ-023 Reset: hold rst_n=0 for 2 edges, then rptr=0 and rptr=1 -> dout=16'h0000 for both.
REQ-024 Write/read: write wptr=0 din=16'hA5A5, write wptr=1 din=16'h5A5A; rptr=0 -> 16'hA5A5, rptr=1 -> 16'h5A5A, each in the same cycle rptr changes.
REQ-025 Same-address write: entry0=16'h1111; rptr=0, wptr=0, wr=1, din=16'h2222 -> dout=16'h1111 before the edge, 16'h2222 after it.
REQ-026 Hold: wr=0 with din toggling for 4 cycles -> stored values unchanged.
REQ-027 Reset priority: rst_n=0 with wr=1, wptr=1, din=16'hFFFF -> entry1 reads 16'h0000 after the edge.
REQ-028 Depth sweep at DEPTH_NBITS=3, WIDTH=8: write 8'h10+i to address i for i=0..7, then read all 8 -> exact match; a wrap write to address 0 overwrites only entry 0.
